// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants for the hazard/mult-div controller.
// Opcodes, functs, mult/div latencies and the hazard compare helper.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;

   localparam logic [1:0] MD_OP_MULT  = 2'd0;
   localparam logic [1:0] MD_OP_MULTU = 2'd1;
   localparam logic [1:0] MD_OP_DIV   = 2'd2;
   localparam logic [1:0] MD_OP_DIVU  = 2'd3;

   // A Tuse of 3 exceeds every Tnew, so it means "not read".
   localparam logic [1:0] TUSE_NONE = 2'd3;

   // Hazard when a source hits a live destination too early.
   function automatic logic hz(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] dst,
      input logic [1:0] tnew
   );
      return (dst != 5'd0) && (src == dst) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational classifier for one pipeline-stage instruction word.
// Yields fields, Tuse per source, Tnew at E and mult/div class flags.
module instr_class
   import mips_defs::*;
(
   input  logic [31:0] ir_i,
   output logic [4:0]  rs_o,
   output logic [4:0]  rt_o,
   output logic [4:0]  dst_o,
   output logic [1:0]  tuse_rs_o,
   output logic [1:0]  tuse_rt_o,
   output logic [1:0]  tnew_o,
   output logic        md_o,
   output logic        md_start_o,
   output logic [1:0]  md_op_o
);

   logic [5:0] op;
   logic [5:0] fn;
   logic [4:0] rd;
   logic       unused_shamt;

   assign op = ir_i[31:26];
   assign fn = ir_i[5:0];
   assign rs_o = ir_i[25:21];
   assign rt_o = ir_i[20:16];
   assign rd = ir_i[15:11];
   assign unused_shamt = ^ir_i[10:6];
   // mult/multu/div/divu funct low bits match the MD_Op encoding
   assign md_op_o = ir_i[1:0];

   // Decode destination, operand timing and mult/div class
   always_comb begin
      dst_o      = 5'd0;
      tuse_rs_o  = TUSE_NONE;
      tuse_rt_o  = TUSE_NONE;
      tnew_o     = 2'd0;
      md_o       = 1'b0;
      md_start_o = 1'b0;
      if (op == OP_RTYPE) begin
         case (fn)
            FN_ADDU, FN_SUBU: begin
               dst_o     = rd;
               tuse_rs_o = 2'd1;
               tuse_rt_o = 2'd1;
               tnew_o    = 2'd1;
            end
            FN_JR: tuse_rs_o = 2'd0;
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
               tuse_rs_o  = 2'd1;
               tuse_rt_o  = 2'd1;
               md_o       = 1'b1;
               md_start_o = 1'b1;
            end
            FN_MFHI, FN_MFLO: begin
               dst_o  = rd;
               tnew_o = 2'd1;
               md_o   = 1'b1;
            end
            FN_MTHI, FN_MTLO: begin
               tuse_rs_o = 2'd1;
               md_o      = 1'b1;
            end
            default: ;
         endcase
      end else begin
         case (op)
            OP_ORI: begin
               dst_o     = rt_o;
               tuse_rs_o = 2'd1;
               tnew_o    = 2'd1;
            end
            OP_LUI: begin
               dst_o  = rt_o;
               tnew_o = 2'd1;
            end
            OP_LW: begin
               dst_o     = rt_o;
               tuse_rs_o = 2'd1;
               tnew_o    = 2'd2;
            end
            OP_SW: begin
               tuse_rs_o = 2'd1;
               tuse_rt_o = 2'd2;
            end
            OP_BEQ: begin
               tuse_rs_o = 2'd0;
               tuse_rt_o = 2'd0;
            end
            OP_JAL: begin
               dst_o  = 5'd31;
               tnew_o = 2'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew stall detection and mult/div busy sequencing.
// Freezes F/D, bubbles ID/EX and counts mult/div latency.
module hazard_ctrl
   import mips_defs::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] IR_D,
   input  logic [31:0] IR_E,
   input  logic [31:0] IR_M,
   output logic        Stall,
   output logic        Clr_E,
   output logic        MD_Start,
   output logic [1:0]  MD_Op,
   output logic        Busy
);

   logic [4:0] rs_d, rt_d, dst_d_unused;
   logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d_unused;
   logic       md_d, mds_d_unused;
   logic [1:0] mdop_d_unused;

   logic [4:0] rs_e_unused, rt_e_unused, dst_e;
   logic [1:0] tur_e_unused, tut_e_unused, tnew_e;
   logic       md_e_unused, mds_e;
   logic [1:0] mdop_e;

   logic [4:0] rs_m_unused, rt_m_unused, dst_m;
   logic [1:0] tur_m_unused, tut_m_unused, tnew_e_m;
   logic       md_m_unused, mds_m_unused;
   logic [1:0] mdop_m_unused;

   logic [1:0] tnew_m;
   logic       data_stall;
   logic       md_stall;
   logic       start;
   logic       is_div;
   logic [3:0] cnt_q, cnt_d;

   instr_class u_cls_d (
      .ir_i       (IR_D),
      .rs_o       (rs_d),
      .rt_o       (rt_d),
      .dst_o      (dst_d_unused),
      .tuse_rs_o  (tuse_rs_d),
      .tuse_rt_o  (tuse_rt_d),
      .tnew_o     (tnew_d_unused),
      .md_o       (md_d),
      .md_start_o (mds_d_unused),
      .md_op_o    (mdop_d_unused)
   );

   instr_class u_cls_e (
      .ir_i       (IR_E),
      .rs_o       (rs_e_unused),
      .rt_o       (rt_e_unused),
      .dst_o      (dst_e),
      .tuse_rs_o  (tur_e_unused),
      .tuse_rt_o  (tut_e_unused),
      .tnew_o     (tnew_e),
      .md_o       (md_e_unused),
      .md_start_o (mds_e),
      .md_op_o    (mdop_e)
   );

   instr_class u_cls_m (
      .ir_i       (IR_M),
      .rs_o       (rs_m_unused),
      .rt_o       (rt_m_unused),
      .dst_o      (dst_m),
      .tuse_rs_o  (tur_m_unused),
      .tuse_rt_o  (tut_m_unused),
      .tnew_o     (tnew_e_m),
      .md_o       (md_m_unused),
      .md_start_o (mds_m_unused),
      .md_op_o    (mdop_m_unused)
   );

   // One stage later the producer is one cycle closer to done
   assign tnew_m = (tnew_e_m != 2'd0) ? tnew_e_m - 2'd1 : 2'd0;

   // Source-vs-destination comparators against E and M
   always_comb begin
      data_stall = hz(rs_d, tuse_rs_d, dst_e, tnew_e)
                 | hz(rt_d, tuse_rt_d, dst_e, tnew_e)
                 | hz(rs_d, tuse_rs_d, dst_m, tnew_m)
                 | hz(rt_d, tuse_rt_d, dst_m, tnew_m);
   end

   assign start    = mds_e & ~Reset;
   assign is_div   = mdop_e[1];
   assign md_stall = md_d & (start | Busy);
   assign Stall    = ~Reset & (data_stall | md_stall);
   assign Clr_E    = Stall;
   assign MD_Start = start;
   assign MD_Op    = start ? mdop_e : MD_OP_MULT;
   assign Busy     = (cnt_q != 4'd0);

   // Next busy count: load latency on start, else count down
   always_comb begin
      cnt_d = cnt_q;
      if (start)
         cnt_d = is_div ? DIV_CYCLES : MULT_CYCLES;
      else if (cnt_q != 4'd0)
         cnt_d = cnt_q - 4'd1;
   end

   // Busy counter register; reset aborts any operation in flight
   always_ff @(posedge Clk) begin
      if (Reset)
         cnt_q <= 4'd0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with directed vectors.
// Stimulus queues expectations; a negedge monitor compares.
module tb_hazard_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] IR_D = 32'h0;
   logic [31:0] IR_E = 32'h0;
   logic [31:0] IR_M = 32'h0;
   logic        Stall, Clr_E, MD_Start, Busy;
   logic [1:0]  MD_Op;

   localparam logic [31:0] LW1    = 32'h8C010000;
   localparam logic [31:0] LW0    = 32'h8C000000;
   localparam logic [31:0] ADDU21 = 32'h00211021;
   localparam logic [31:0] ADDU1  = 32'h00430821;
   localparam logic [31:0] ADDU0  = 32'h00430021;
   localparam logic [31:0] BEQ1   = 32'h10200000;
   localparam logic [31:0] BEQ00  = 32'h10000000;
   localparam logic [31:0] SW1    = 32'hAC410000;
   localparam logic [31:0] MULT   = 32'h00220018;
   localparam logic [31:0] MULTU  = 32'h00220019;
   localparam logic [31:0] DIV    = 32'h0022001A;
   localparam logic [31:0] DIVU   = 32'h0022001B;
   localparam logic [31:0] MFHI3  = 32'h00001810;
   localparam logic [31:0] MFLO4  = 32'h00002012;
   localparam logic [31:0] MTHI1  = 32'h00200011;

   typedef struct {
      logic       stall;
      logic       start;
      logic [1:0] op;
      logic       busy;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   hazard_ctrl dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .IR_D     (IR_D),
      .IR_E     (IR_E),
      .IR_M     (IR_M),
      .Stall    (Stall),
      .Clr_E    (Clr_E),
      .MD_Start (MD_Start),
      .MD_Op    (MD_Op),
      .Busy     (Busy)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input string sig,
                      input logic [1:0] act, input logic [1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s.%s actual=%0d required=%0d", nm, sig, act, exp);
      end
   endtask

   // Monitor: compare every presented cycle against the queue head
   initial begin
      exp_t x;
      forever begin
         @(negedge Clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.name, "Stall", {1'b0, Stall}, {1'b0, x.stall});
            chk(x.name, "Clr_E", {1'b0, Clr_E}, {1'b0, x.stall});
            chk(x.name, "MD_Start", {1'b0, MD_Start}, {1'b0, x.start});
            chk(x.name, "MD_Op", MD_Op, x.op);
            chk(x.name, "Busy", {1'b0, Busy}, {1'b0, x.busy});
         end
      end
   end

   task automatic step(input logic rst, input logic [31:0] d,
                       input logic [31:0] e, input logic [31:0] m,
                       input logic st, input logic sr,
                       input logic [1:0] op, input logic bz,
                       input string nm);
      exp_t x;
      @(posedge Clk);
      #1;
      Reset = rst;
      IR_D = d;
      IR_E = e;
      IR_M = m;
      x.stall = st;
      x.start = sr;
      x.op = op;
      x.busy = bz;
      x.name = nm;
      sb.push_back(x);
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0, 0, 0, "reset");
      step(1, ADDU21, LW1, 0, 0, 0, 0, 0, "reset_force");
      step(0, ADDU21, LW1, 0, 1, 0, 0, 0, "load_use_E");
      step(0, ADDU21, 0, LW1, 0, 0, 0, 0, "load_use_M");
      step(0, BEQ1, ADDU1, 0, 1, 0, 0, 0, "beq_addu_E");
      step(0, BEQ1, 0, ADDU1, 0, 0, 0, 0, "beq_addu_M");
      step(0, SW1, LW1, 0, 0, 0, 0, 0, "sw_after_lw");
      step(0, BEQ1, LW1, 0, 1, 0, 0, 0, "beq_lw_E");
      step(0, BEQ1, 0, LW1, 1, 0, 0, 0, "beq_lw_M");
      step(0, BEQ1, 0, 0, 0, 0, 0, 0, "beq_free");
      step(0, BEQ00, ADDU0, LW0, 0, 0, 0, 0, "reg_zero");
      step(0, MFHI3, MULT, 0, 1, 1, 0, 0, "mult_start");
      for (int i = 0; i < 5; i++)
         step(0, MFHI3, 0, 0, 1, 0, 0, 1, "mult_busy");
      step(0, MFHI3, 0, 0, 0, 0, 0, 0, "mult_done");
      step(0, 0, MFHI3, 0, 0, 0, 0, 0, "mfhi_moved");
      step(0, MFLO4, DIV, 0, 1, 1, 2, 0, "div_start");
      for (int i = 0; i < 3; i++)
         step(0, MFLO4, 0, 0, 1, 0, 0, 1, "div_busy");
      step(1, MFLO4, DIV, 0, 0, 0, 0, 1, "div_reset");
      step(0, MFLO4, 0, 0, 0, 0, 0, 0, "div_abort");
      step(0, 0, DIVU, 0, 0, 1, 3, 0, "divu_start");
      step(0, MTHI1, LW1, 0, 1, 0, 0, 1, "dual_stall");
      for (int i = 0; i < 9; i++)
         step(0, 0, 0, 0, 0, 0, 0, 1, "divu_busy");
      step(0, 0, 0, 0, 0, 0, 0, 0, "divu_done");
      step(0, 0, MULTU, 0, 0, 1, 1, 0, "multu_start");
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, 0, 0, 0, 0, 1, "multu_busy");
      step(0, 0, 0, 0, 0, 0, 0, 0, "multu_done");
      for (int i = 0; i < 20 && sb.size() > 0; i++)
         @(posedge Clk);
      if (sb.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
